// File: rtl/bool_chk_pkg.sv
// Shared definitions for the boolean sweep checker: FSM state encoding and
// sweep limits.
package bool_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam int         NUM_VECTORS = 16;
  localparam logic [3:0] LAST_VEC    = 4'(NUM_VECTORS - 1);

endpackage

// File: rtl/bool_golden.sv
// Golden model of the expression logic under test:
//   F = A&B | ~C,  G = (A^B) & (C|D), with abcd = {A,B,C,D}.
module bool_golden (
  input  logic [3:0] abcd,
  output logic       f_gold,
  output logic       g_gold
);

  logic a, b, c, d;

  assign {a, b, c, d} = abcd;
  assign f_gold       = (a & b) | ~c;
  assign g_gold       = (a ^ b) & (c | d);

endmodule

// File: rtl/bool_sweep_checker.sv
// Self-test sweeper for the F/G expression logic. Drives abcd = 0..15, waits
// SETTLE_CYCLES per vector, compares f_in/g_in against bool_golden and reports
// a saturating mismatch count, the first failing vector and pass/fail.
// Optional build macro BOOL_CHK_STOP_ON_ERR_EN: end the sweep at the first
// mismatch, leaving abcd frozen at the failing vector.
module bool_sweep_checker
  import bool_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       abcd,
  input  logic             f_in,
  input  logic             g_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_err_vec,
  output logic             first_err_valid
);

  localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("bool_sweep_checker: SETTLE_CYCLES must be >= 1");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] settle_cnt;
  logic             f_gold, g_gold;
  logic             mismatch;
  logic             settle_last;

  bool_golden u_golden (
    .abcd   (abcd),
    .f_gold (f_gold),
    .g_gold (g_gold)
  );

  // A vector counts once even when both F and G disagree.
  assign mismatch    = (f_in != f_gold) || (g_in != g_gold);
  assign settle_last = (settle_cnt == SETTLE_LAST);

  // Next-state decode; done is a Moore output of FIN.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:   if (start) state_next = SETTLE;
      SETTLE: if (settle_last) state_next = CHECK;
      CHECK: begin
        state_next = (abcd == LAST_VEC) ? FIN : SETTLE;
`ifdef BOOL_CHK_STOP_ON_ERR_EN
        if (mismatch) state_next = FIN;
`endif
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus sweep datapath and scoreboard, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state           <= IDLE;
      abcd            <= '0;
      busy            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
      settle_cnt      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            abcd            <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            settle_cnt      <= '0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + CNT_W'(1);
        CHECK: begin
          if (mismatch) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
            if (!first_err_valid) begin
              first_err_vec   <= abcd;
              first_err_valid <= 1'b1;
            end
          end
          if (state_next == SETTLE) begin
            abcd       <= abcd + 4'd1;
            settle_cnt <= '0;
          end
        end
        FIN: begin
          // err_cnt already includes the last CHECK here.
          pass <= (err_cnt == '0);
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
